// File: rtl/go_launch_ctrl.sv
// Launch controller that follows an upstream READY/SET/GO phase sequence and
// emits one held launch per GO, flagging sequence errors with a sticky cause.
module go_launch_ctrl #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             get_ready,
    input  logic             get_set,
    input  logic             get_going,
    input  logic             launch_ack,
    input  logic             clr_err,
    output logic             launch_valid,
    output logic [CNT_W-1:0] launch_id,
    output logic             seq_err,
    output logic [1:0]       err_code,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        PRIMED = 3'd2,
        FIRED  = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [1:0] E_NONE  = 2'b00;
    localparam logic [1:0] E_MULTI = 2'b01;
    localparam logic [1:0] E_ORDER = 2'b10;
    localparam logic [1:0] E_OVER  = 2'b11;

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] next_id;
    logic [2:0]       phase;
    logic             launch_try;
    logic             launch_ok;
    logic             err_hit;
    logic [1:0]       err_cause;

    function automatic logic multi_hot(input logic [2:0] p);
        return (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign phase = {get_ready, get_set, get_going};

    always_comb begin
        nxt_state  = state;
        launch_try = 1'b0;
        launch_ok  = 1'b0;
        err_hit    = 1'b0;
        err_cause  = E_NONE;

        if (state == ERROR) begin
            if (clr_err) nxt_state = IDLE;
        end else if (multi_hot(phase)) begin
            err_hit   = 1'b1;
            err_cause = E_MULTI;
        end else begin
            unique case (state)
                IDLE: begin
                    if (get_ready)                  nxt_state = ARMED;
                    else if (get_set || get_going)  begin err_hit = 1'b1; err_cause = E_ORDER; end
                    else                            nxt_state = IDLE;
                end
                ARMED: begin
                    if (get_set)                    nxt_state = PRIMED;
                    else if (get_ready)             nxt_state = ARMED;
                    else if (get_going)             begin err_hit = 1'b1; err_cause = E_ORDER; end
                    else                            nxt_state = IDLE;
                end
                PRIMED: begin
                    if (get_going)                  launch_try = 1'b1;
                    else if (get_set)               nxt_state = PRIMED;
                    else if (get_ready)             begin err_hit = 1'b1; err_cause = E_ORDER; end
                    else                            nxt_state = IDLE;
                end
                FIRED: begin
                    if (get_ready)                  nxt_state = ARMED;
                    else if (get_set || get_going)  begin err_hit = 1'b1; err_cause = E_ORDER; end
                    else                            nxt_state = IDLE;
                end
                default:                            nxt_state = IDLE;
            endcase
        end

        // A GO can only launch if the previous launch is gone or leaving this cycle.
        if (launch_try) begin
            if (!launch_valid || launch_ack) begin
                launch_ok = 1'b1;
                nxt_state = FIRED;
            end else begin
                err_hit   = 1'b1;
                err_cause = E_OVER;
            end
        end

        if (err_hit) nxt_state = ERROR;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            launch_valid <= 1'b0;
            launch_id    <= '0;
            next_id      <= '0;
            seq_err      <= 1'b0;
            err_code     <= E_NONE;
            err_count    <= '0;
        end else begin
            state <= nxt_state;

            if (err_hit) begin
                seq_err   <= 1'b1;
                err_code  <= err_cause;
                err_count <= sat_inc(err_count);
            end else if (state == ERROR && clr_err) begin
                seq_err  <= 1'b0;
                err_code <= E_NONE;
            end

            // A pending launch survives ERROR and clr_err; only ack or reset retires it.
            if (launch_ok) begin
                launch_valid <= 1'b1;
                launch_id    <= next_id;
                next_id      <= next_id + 1'b1;
            end else if (launch_valid && launch_ack) begin
                launch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/go_launch_ctrl.md
GO_LAUNCH_CTRL -- requirements
Module: go_launch_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of launch_id.
REQ-002 Parameter ERR_W, default 4, width of err_count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 get_ready  input  1  upstream FSM READY phase flag.
REQ-006 get_set  input  1  upstream FSM SET phase flag.
REQ-007 get_going  input  1  upstream FSM GO phase flag.
REQ-008 launch_ack  input  1  downstream accepts the pending launch.
REQ-009 clr_err  input  1  single-cycle request to leave ERROR.
REQ-010 launch_valid  output  1  launch pending; held until acknowledged.
REQ-011 launch_id  output  CNT_W  sequence number of the pending launch.
REQ-012 seq_err  output  1  high while in ERROR.
REQ-013 err_code  output  2  cause of the current error: 00 none, 01 multi-hot, 10 out-of-order, 11 overrun.
REQ-014 err_count  output  ERR_W  saturating count of error entries.

Function
REQ-015 Phase vector P = {get_ready, get_set, get_going}; all outputs are registered.
REQ-016 The phase FSM SHALL have the states IDLE, ARMED, PRIMED, FIRED and ERROR.
REQ-017 Outside ERROR, more than one bit of P high -> ERROR with code 01; this check has the highest priority.
REQ-018 IDLE: ready -> ARMED; set or go -> ERROR 10; none -> IDLE.
REQ-019 ARMED: set -> PRIMED; ready -> ARMED; go -> ERROR 10; none -> IDLE.
REQ-020 PRIMED: go -> FIRED plus a launch attempt; set -> PRIMED; ready -> ERROR 10; none -> IDLE.
REQ-021 FIRED: ready -> ARMED; set or go -> ERROR 10; none -> IDLE.
REQ-022 ERROR: P is ignored; clr_err -> IDLE with err_code cleared to 00; otherwise stay in ERROR.
REQ-023 clr_err outside ERROR SHALL have no effect.
REQ-024 First error wins: err_code is captured on ERROR entry and held while in ERROR.
REQ-025 err_count increments by 1 on each ERROR entry, saturates at 2^ERR_W-1, and is not cleared by clr_err.
REQ-026 A launch attempt succeeds if launch_valid is 0, or launch_valid is 1 and launch_ack is 1 in the same cycle.
REQ-027 Success: launch_valid=1 and launch_id=next_id at the next edge (1-cycle latency from go).
REQ-028 Failure, i.e. launch still pending: -> ERROR 11 instead of FIRED; the pending launch is kept unchanged.
REQ-029 next_id starts at 0, increments on each successful launch, and wraps modulo 2^CNT_W.
REQ-030 launch_valid SHALL NOT fall without launch_ack.
REQ-031 Handshake rule: launch_valid and launch_ack both high at an edge, with no new launch -> launch_valid=0 at the next edge.
REQ-032 launch_id SHALL be stable while launch_valid=1 and not acknowledged.
REQ-033 A pending launch persists through ERROR and through clr_err until acknowledged.
REQ-034 No new launch SHALL be generated in ERROR.
REQ-035 launch_ack while launch_valid=0 SHALL be ignored.

Reset
REQ-036 rstN low SHALL immediately force the FSM to IDLE.
REQ-037 rstN low SHALL immediately clear launch_valid, launch_id, next_id, seq_err, err_code and err_count to 0, independent of clk.
REQ-038 Reset during a pending launch SHALL discard that launch.
REQ-039 On the first edge after rstN rises, the block SHALL process inputs as from IDLE.

Verification
REQ-040 Phases ready,set,go repeated twice with launch_ack=1 -> launch_valid high one cycle after each go, with launch_id 0 then 1; seq_err=0.
REQ-041 launch_ack=0 across two full ready,set,go loops -> second go gives seq_err=1 and err_code=11; launch_valid stays 1 with launch_id=0 until ack.
REQ-042 In ARMED, drive P=110 -> seq_err=1, err_code=01, err_count=1.
REQ-043 go from IDLE -> err_code=10; then clr_err -> IDLE with err_code=00 and err_count=1 retained.
REQ-044 CNT_W=2, ERR_W=2: five acked launches give ids 0,1,2,3,0; five error entries leave err_count=3.
REQ-045 rstN low mid-cycle while launch_valid=1 -> all outputs 0 before the next clk edge; a ready,set,go after release gives launch_id=0.
